// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the MIPS-subset datapath (IF/ID/EXE/MEM/WB).
// Optional feature: define ADDI_OVF_EN to support addi with overflow trap ($30 <= 1).
module mc_ctrl #(
    parameter logic [2:0] ALU_ADD  = 3'b000,
    parameter logic [2:0] ALU_SUB  = 3'b001,
    parameter logic [2:0] ALU_OR   = 3'b010,
    parameter logic [2:0] EXT_ZERO = 3'b000,
    parameter logic [2:0] EXT_SIGN = 3'b001,
    parameter logic [2:0] EXT_LUI  = 3'b010
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       overflow_flag,
    output logic       PCWr,
    output logic       IRWr,
    output logic       GPRWr,
    output logic       DMWr,
    output logic [1:0] npc_sel,
    output logic [1:0] reg_dst,
    output logic [1:0] wd_sel,
    output logic       alu_src_b,
    output logic [2:0] alu_sel,
    output logic [2:0] ext_sel,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        I_ADDU, I_SUBU, I_JR, I_ORI, I_LUI, I_LW,
        I_SW, I_BEQ, I_J, I_JAL, I_ADDI, I_ILL
    } instr_t;

    state_t cur;
    instr_t kind;
    logic   ovf_q;

    assign state = cur;

    always_comb begin
        kind = I_ILL;
        case (op)
            6'h00: begin
                case (funct)
                    6'h21:   kind = I_ADDU;
                    6'h23:   kind = I_SUBU;
                    6'h08:   kind = I_JR;
                    default: kind = I_ILL;
                endcase
            end
            6'h0D: kind = I_ORI;
            6'h0F: kind = I_LUI;
            6'h23: kind = I_LW;
            6'h2B: kind = I_SW;
            6'h04: kind = I_BEQ;
            6'h02: kind = I_J;
            6'h03: kind = I_JAL;
`ifdef ADDI_OVF_EN
            6'h08: kind = I_ADDI;
`endif
            default: kind = I_ILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur <= S_IF;
        end else begin
            case (cur)
                S_IF: cur <= S_ID;
                S_ID: begin
                    if (kind == I_J || kind == I_JAL || kind == I_JR || kind == I_ILL)
                        cur <= S_IF;
                    else
                        cur <= S_EXE;
                end
                S_EXE: begin
                    if (kind == I_LW || kind == I_SW)
                        cur <= S_MEM;
                    else if (kind == I_BEQ || kind == I_ILL)
                        cur <= S_IF;
                    else
                        cur <= S_WB;
                end
                S_MEM:   cur <= (kind == I_LW) ? S_WB : S_IF;
                S_WB:    cur <= S_IF;
                default: cur <= S_IF;
            endcase
        end
    end

`ifdef ADDI_OVF_EN
    // Overflow of addi is captured at the end of EXE and only consumed by the following WB.
    always_ff @(posedge clk) begin
        if (rst)
            ovf_q <= 1'b0;
        else if (cur == S_EXE)
            ovf_q <= (kind == I_ADDI) && overflow_flag;
    end
`else
    logic unused_ovf;
    assign unused_ovf = overflow_flag;
    assign ovf_q      = 1'b0;
`endif

    // Datapath selects are decoded from the instruction from EXE onward so they stay stable through WB.
    always_comb begin
        PCWr      = 1'b0;
        IRWr      = 1'b0;
        GPRWr     = 1'b0;
        DMWr      = 1'b0;
        npc_sel   = 2'b00;
        reg_dst   = 2'b00;
        wd_sel    = 2'b00;
        alu_src_b = 1'b0;
        alu_sel   = ALU_ADD;
        ext_sel   = EXT_ZERO;
        if (!rst) begin
            if (cur == S_EXE || cur == S_MEM || cur == S_WB) begin
                case (kind)
                    I_SUBU, I_BEQ: alu_sel = ALU_SUB;
                    I_ORI, I_LUI:  alu_sel = ALU_OR;
                    default:       alu_sel = ALU_ADD;
                endcase
                alu_src_b = (kind == I_ORI || kind == I_LUI || kind == I_LW ||
                             kind == I_SW  || kind == I_ADDI);
                case (kind)
                    I_LUI:               ext_sel = EXT_LUI;
                    I_LW, I_SW, I_ADDI:  ext_sel = EXT_SIGN;
                    default:             ext_sel = EXT_ZERO;
                endcase
                if (kind == I_ADDU || kind == I_SUBU) reg_dst = 2'b01;
                if (kind == I_LW) wd_sel = 2'b01;
            end
            case (cur)
                S_IF: begin
                    PCWr = 1'b1;
                    IRWr = 1'b1;
                end
                S_ID: begin
                    case (kind)
                        I_J: begin
                            PCWr    = 1'b1;
                            npc_sel = 2'b10;
                        end
                        I_JAL: begin
                            PCWr    = 1'b1;
                            npc_sel = 2'b10;
                            GPRWr   = 1'b1;
                            reg_dst = 2'b10;
                            wd_sel  = 2'b10;
                        end
                        I_JR: begin
                            PCWr    = 1'b1;
                            npc_sel = 2'b11;
                        end
                        default: ;
                    endcase
                end
                S_EXE: begin
                    if (kind == I_BEQ) begin
                        PCWr    = zero;
                        npc_sel = 2'b01;
                    end
                end
                S_MEM: DMWr = (kind == I_SW);
                S_WB: begin
                    GPRWr = (kind == I_ADDU || kind == I_SUBU || kind == I_ORI ||
                             kind == I_LUI  || kind == I_LW   || kind == I_ADDI);
                    if (kind == I_ADDI && ovf_q) begin
                        reg_dst = 2'b11;
                        wd_sel  = 2'b11;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed self-checking bench for mc_ctrl; covers ADDI_OVF_EN when that macro is defined.
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       overflow_flag;
    logic       PCWr, IRWr, GPRWr, DMWr, alu_src_b;
    logic [1:0] npc_sel, reg_dst, wd_sel;
    logic [2:0] alu_sel, ext_sel, state;

    int assertCount = 0;
    int failCount   = 0;

    mc_ctrl dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
        .overflow_flag(overflow_flag), .PCWr(PCWr), .IRWr(IRWr), .GPRWr(GPRWr),
        .DMWr(DMWr), .npc_sel(npc_sel), .reg_dst(reg_dst), .wd_sel(wd_sel),
        .alu_src_b(alu_src_b), .alu_sel(alu_sel), .ext_sel(ext_sel), .state(state)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [5:0] o, input logic [5:0] f, input logic z, input logic v);
        op            = o;
        funct         = f;
        zero          = z;
        overflow_flag = v;
    endtask

    // Runs one instruction from IF and checks the number of cycles until IF comes round again.
    task automatic runLatency(input logic [5:0] o, input logic [5:0] f, input int expLat, input string tag);
        int n;
        applyStimulus(o, f, 1'b0, 1'b0);
        checkOutput({tag, "_start_if"}, state, 0);
        n = 0;
        do begin
            tick();
            n++;
        end while (state != 3'd0 && n < 12);
        checkOutput({tag, "_latency"}, n, expLat);
    endtask

    initial begin
        int gprSeen;
        rst = 1'b1;
        applyStimulus(6'h00, 6'h21, 1'b0, 1'b0);

        // Reset held two cycles: everything gated off.
        tick();
        checkOutput("rst1_pcwr", PCWr, 0);
        checkOutput("rst1_irwr", IRWr, 0);
        tick();
        checkOutput("rst2_gprwr", GPRWr, 0);
        checkOutput("rst2_state", state, 0);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_pcwr", PCWr, 1);
        checkOutput("post_rst_irwr", IRWr, 1);

        // addu: IF, ID, EXE, WB
        checkOutput("addu_if_npc", npc_sel, 0);
        tick();
        checkOutput("addu_id_state", state, 1);
        checkOutput("addu_id_pcwr", PCWr, 0);
        tick();
        checkOutput("addu_exe_state", state, 2);
        checkOutput("addu_exe_alu", alu_sel, 3'b000);
        checkOutput("addu_exe_srcb", alu_src_b, 0);
        checkOutput("addu_exe_pcwr", PCWr, 0);
        tick();
        checkOutput("addu_wb_state", state, 4);
        checkOutput("addu_wb_gprwr", GPRWr, 1);
        checkOutput("addu_wb_regdst", reg_dst, 2'b01);
        checkOutput("addu_wb_wdsel", wd_sel, 2'b00);
        checkOutput("addu_wb_pcwr", PCWr, 0);
        tick();
        checkOutput("addu_back_if", state, 0);

        // subu / ori / lui EXE selects
        applyStimulus(6'h00, 6'h23, 1'b0, 1'b0);
        tick(); tick();
        checkOutput("subu_exe_alu", alu_sel, 3'b001);
        tick(); tick();
        applyStimulus(6'h0D, 6'h00, 1'b0, 1'b0);
        tick(); tick();
        checkOutput("ori_exe_alu", alu_sel, 3'b010);
        checkOutput("ori_exe_srcb", alu_src_b, 1);
        checkOutput("ori_exe_ext", ext_sel, 3'b000);
        tick();
        checkOutput("ori_wb_regdst", reg_dst, 2'b00);
        checkOutput("ori_wb_gprwr", GPRWr, 1);
        tick();
        applyStimulus(6'h0F, 6'h00, 1'b0, 1'b0);
        tick(); tick();
        checkOutput("lui_exe_ext", ext_sel, 3'b010);
        checkOutput("lui_exe_alu", alu_sel, 3'b010);
        tick(); tick();

        // beq taken then not taken
        applyStimulus(6'h04, 6'h00, 1'b1, 1'b0);
        tick(); tick();
        checkOutput("beq_t_exe_pcwr", PCWr, 1);
        checkOutput("beq_t_exe_npc", npc_sel, 2'b01);
        checkOutput("beq_t_exe_alu", alu_sel, 3'b001);
        tick();
        checkOutput("beq_t_back_if", state, 0);
        applyStimulus(6'h04, 6'h00, 1'b0, 1'b0);
        tick(); tick();
        checkOutput("beq_nt_exe_pcwr", PCWr, 0);
        checkOutput("beq_nt_exe_npc", npc_sel, 2'b01);
        tick();
        checkOutput("beq_nt_back_if", state, 0);

        // lw: IF, ID, EXE, MEM, WB
        applyStimulus(6'h23, 6'h00, 1'b0, 1'b0);
        tick(); tick();
        checkOutput("lw_exe_srcb", alu_src_b, 1);
        checkOutput("lw_exe_ext", ext_sel, 3'b001);
        checkOutput("lw_exe_alu", alu_sel, 3'b000);
        tick();
        checkOutput("lw_mem_state", state, 3);
        checkOutput("lw_mem_dmwr", DMWr, 0);
        checkOutput("lw_mem_ext_held", ext_sel, 3'b001);
        tick();
        checkOutput("lw_wb_gprwr", GPRWr, 1);
        checkOutput("lw_wb_wdsel", wd_sel, 2'b01);
        checkOutput("lw_wb_regdst", reg_dst, 2'b00);
        tick();
        checkOutput("lw_back_if", state, 0);

        // sw: GPRWr never asserted, DMWr in MEM
        applyStimulus(6'h2B, 6'h00, 1'b0, 1'b0);
        gprSeen = 0;
        for (int i = 0; i < 4; i++) begin
            if (state == 3'd3) checkOutput("sw_mem_dmwr", DMWr, 1);
            gprSeen = gprSeen | int'(GPRWr);
            tick();
        end
        checkOutput("sw_gprwr_seen", gprSeen, 0);
        checkOutput("sw_back_if", state, 0);

        // jal in ID
        applyStimulus(6'h03, 6'h00, 1'b0, 1'b0);
        tick();
        checkOutput("jal_id_pcwr", PCWr, 1);
        checkOutput("jal_id_npc", npc_sel, 2'b10);
        checkOutput("jal_id_gprwr", GPRWr, 1);
        checkOutput("jal_id_regdst", reg_dst, 2'b10);
        checkOutput("jal_id_wdsel", wd_sel, 2'b10);
        tick();
        checkOutput("jal_back_if", state, 0);

        // jr and illegal in ID
        applyStimulus(6'h00, 6'h08, 1'b0, 1'b0);
        tick();
        checkOutput("jr_id_npc", npc_sel, 2'b11);
        checkOutput("jr_id_pcwr", PCWr, 1);
        tick();
        applyStimulus(6'h3F, 6'h00, 1'b0, 1'b0);
        tick();
        checkOutput("ill_id_pcwr", PCWr, 0);
        checkOutput("ill_id_gprwr", GPRWr, 0);
        tick();

        // Latency table
        runLatency(6'h02, 6'h00, 2, "j");
        runLatency(6'h03, 6'h00, 2, "jal");
        runLatency(6'h00, 6'h08, 2, "jr");
        runLatency(6'h00, 6'h3F, 2, "ill_funct");
        runLatency(6'h04, 6'h00, 3, "beq");
        runLatency(6'h00, 6'h21, 4, "addu");
        runLatency(6'h0D, 6'h00, 4, "ori");
        runLatency(6'h0F, 6'h00, 4, "lui");
        runLatency(6'h2B, 6'h00, 4, "sw");
        runLatency(6'h23, 6'h00, 5, "lw");

        // Reset mid-instruction: addu abandoned in EXE
        applyStimulus(6'h00, 6'h21, 1'b0, 1'b0);
        tick(); tick();
        rst = 1'b1;
        #1;
        checkOutput("rst_exe_pcwr", PCWr, 0);
        checkOutput("rst_exe_alu", alu_sel, 3'b000);
        tick();
        rst = 1'b0;
        #1;
        checkOutput("rst_exe_next_if", state, 0);
        checkOutput("rst_exe_next_pcwr", PCWr, 1);

`ifdef ADDI_OVF_EN
        // addi overflowing: $30 <= 1 instead of rt
        applyStimulus(6'h08, 6'h00, 1'b0, 1'b0);
        tick(); tick();
        overflow_flag = 1'b1;
        checkOutput("addi_exe_srcb", alu_src_b, 1);
        checkOutput("addi_exe_ext", ext_sel, 3'b001);
        tick();
        overflow_flag = 1'b0;
        checkOutput("addi_ovf_wb_gprwr", GPRWr, 1);
        checkOutput("addi_ovf_wb_regdst", reg_dst, 2'b11);
        checkOutput("addi_ovf_wb_wdsel", wd_sel, 2'b11);
        tick();
        // addi without overflow writes rt
        tick(); tick();
        tick();
        checkOutput("addi_ok_wb_regdst", reg_dst, 2'b00);
        checkOutput("addi_ok_wb_wdsel", wd_sel, 2'b00);
        checkOutput("addi_ok_wb_gprwr", GPRWr, 1);
        tick();
        // addi overflowing, reset raised in EXE
        tick(); tick();
        overflow_flag = 1'b1;
        rst = 1'b1;
        #1;
        checkOutput("addi_rst_gprwr", GPRWr, 0);
        tick();
        rst = 1'b0;
        overflow_flag = 1'b0;
        #1;
        checkOutput("addi_rst_state", state, 0);
        checkOutput("addi_rst_gprwr_if", GPRWr, 0);
        runLatency(6'h08, 6'h00, 4, "addi");
`else
        runLatency(6'h08, 6'h00, 2, "addi_illegal");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
